iq_byte_merge: RTL and testbench
================================

// Module: iq_byte_merge
// PURPOSE
//  Front end of the FM demodulator. Takes the interleaved offset-binary 8-bit I/Q byte
//  stream from the SDR interface (I first, then Q) and merges each pair into one signed
//  WIDTH-bit complex sample. Outputs feed conj_c_mult directly: real_o/imag_o drive
//  real_i/imag_i, and merge_finished_o drives merge_finished_i.
// PARAMETERS
//  WIDTH     16   output sample width; must be >= 8
//  TIMEOUT   255  idle cycles allowed in S_Q before a half-received pair is dropped; >= 1
//  DC_SHIFT  10   DC-estimate time constant (2^DC_SHIFT samples); used only with the macro
// PORTS
//  clk               in   1      system clock; all logic on posedge
//  rst               in   1      synchronous reset, active-high
//  byte_valid_i      in   1      byte_i is valid this cycle
//  byte_i            in   8      offset-binary sample byte (0x80 = zero)
//  sync_i            in   1      with byte_valid_i: this byte is an I byte; alone: realign to S_I
//  real_o            out  WIDTH  signed I sample, held between updates
//  imag_o            out  WIDTH  signed Q sample, held between updates
//  merge_finished_o  out  1      1-cycle strobe: new real_o/imag_o pair valid
//  desync_o          out  1      sticky: sync_i arrived mid-pair or a pair timed out
// BEHAVIOUR
//  - Reset: state S_I; real_o=0, imag_o=0, merge_finished_o=0, desync_o=0; I holding
//    register, timeout counter and DC accumulators all cleared. Reset overrides every
//    input, including mid-pair: the held I byte is discarded.
//  - Conversion: s = byte_i - 128 (signed 8-bit, -128..127); x = s <<< (WIDTH-8).
//    Example (WIDTH=16): 0xFF -> 0x7F00, 0x00 -> 0x8000.
//  - FSM with two states:
//    S_I: on byte_valid_i, latch I byte, clear timeout counter, go to S_Q.
//    S_Q: on byte_valid_i && !sync_i, take the byte as Q. On the next cycle
//      real_o/imag_o update together and merge_finished_o=1 for exactly that cycle.
//      Then return to S_I.
//  - Latency: Q byte accepted at cycle n -> outputs and strobe at n+1. Back-to-back bytes
//    on every cycle are supported, giving one pair per 2 cycles with no stall.
//  - sync_i && byte_valid_i:
//    in S_I: normal I byte.
//    in S_Q: discard the held I, latch this byte as the new I, stay in S_Q, set desync_o.
//  - sync_i without byte_valid_i:
//    in S_Q: drop the held I, go to S_I, set desync_o.
//    in S_I: no effect.
//  - Timeout: in S_Q the counter increments each cycle without byte_valid_i. When it
//    reaches TIMEOUT, drop the held I, go to S_I and set desync_o; no strobe is emitted.
//    A byte arriving on the same cycle the count reaches TIMEOUT is taken as Q (byte wins).
//  - desync_o is cleared only by rst.
//  - Outputs change only on a strobe cycle; otherwise they hold their last value.
// CONFIGURATION
//  IQ_DC_REMOVE_EN defined:
//  - Per channel, dc = acc >>> DC_SHIFT, using a signed accumulator of WIDTH+DC_SHIFT+1
//    bits. On each completed pair, out = sat_WIDTH(x - dc) and acc <= acc + (x - dc),
//    both computed from the pre-update acc.
//  - Saturation clamps to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. Latency and strobe timing are
//    unchanged.
//  IQ_DC_REMOVE_EN not defined:
//  - out = x. No accumulators are synthesised and DC_SHIFT is ignored.
// TESTING  (WIDTH=16, TIMEOUT=255, macro off unless stated)
//  1. Bytes 0x80,0x80 on consecutive cycles -> 1 cycle after Q: real_o=0, imag_o=0,
//     one strobe.
//  2. Bytes 0xFF,0x00 -> real_o=0x7F00 (32512), imag_o=0x8000 (-32768).
//  3. Continuous stream 0x90,0x70,0xA0,0x60 -> strobes 2 cycles apart:
//     (0x1000,0xF000) then (0x2000,0xE000).
//  4. I=0x90, then sync_i with 0x10, then Q=0xA0 -> desync_o=1,
//     real_o=0x9000 (-28672), imag_o=0x2000.
//  5. I byte then 255 idle cycles -> no strobe, desync_o=1; next bytes 0x81,0x82 ->
//     real_o=0x0100, imag_o=0x0200.
//  6. Assert rst between I and Q -> all outputs 0; next pair 0x88,0x78 ->
//     (0x0800,0xF800). With IQ_DC_REMOVE_EN: constant 0xA0/0xA0 stream ->
//     first output 0x2000, decaying toward 0 over ~2^10 pairs.

Source files
------------

// File: rtl/iq_byte_merge.sv
// Merges an interleaved offset-binary I/Q byte stream into signed WIDTH-bit complex samples.
// Optional DC removal is compiled in when IQ_DC_REMOVE_EN is defined.
module iq_byte_merge #(
    parameter int WIDTH    = 16,
    parameter int TIMEOUT  = 255,
    parameter int DC_SHIFT = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    byte_valid_i,
    input  logic [7:0]              byte_i,
    input  logic                    sync_i,
    output logic signed [WIDTH-1:0] real_o,
    output logic signed [WIDTH-1:0] imag_o,
    output logic                    merge_finished_o,
    output logic                    desync_o
);

    // state | meaning
    // S_I   | waiting for the I byte of a pair
    // S_Q   | I byte held, waiting for the Q byte (timeout counter running)
    typedef enum logic {S_I, S_Q} state_t;

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    if (WIDTH < 8 || TIMEOUT < 1 || DC_SHIFT < 0) begin : g_param_check
        $error("iq_byte_merge: invalid parameter value");
    end

    state_t                  state_q, state_d;
    logic [7:0]              ibyte_q, ibyte_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    desync_q, desync_d;
    logic                    strobe_q;
    logic                    pair_done;
    logic signed [WIDTH-1:0] real_q, real_d;
    logic signed [WIDTH-1:0] imag_q, imag_d;
    logic signed [WIDTH-1:0] x_i, x_q;

    function automatic logic signed [WIDTH-1:0] to_sample(input logic [7:0] b);
        logic signed [7:0]       s;
        logic signed [WIDTH-1:0] e;
        s = $signed(b ^ 8'h80);
        e = WIDTH'(s);
        return e <<< (WIDTH - 8);
    endfunction

    assign x_i = to_sample(ibyte_q);
    assign x_q = to_sample(byte_i);

    always_comb begin
        state_d   = state_q;
        ibyte_d   = ibyte_q;
        cnt_d     = cnt_q;
        desync_d  = desync_q;
        pair_done = 1'b0;
        case (state_q)
            S_I: begin
                if (byte_valid_i) begin
                    ibyte_d = byte_i;
                    cnt_d   = '0;
                    state_d = S_Q;
                end
            end
            S_Q: begin
                if (byte_valid_i && !sync_i) begin
                    pair_done = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_I;
                end else if (byte_valid_i) begin
                    // A sync-tagged byte mid-pair restarts the pair with this byte as I.
                    ibyte_d  = byte_i;
                    cnt_d    = '0;
                    desync_d = 1'b1;
                end else if (sync_i || cnt_q == CNT_LAST) begin
                    cnt_d    = '0;
                    desync_d = 1'b1;
                    state_d  = S_I;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_I;
        endcase
    end

`ifdef IQ_DC_REMOVE_EN
    localparam int AW = WIDTH + DC_SHIFT + 1;
    localparam logic signed [AW-1:0] SAT_MAX = {{(AW - WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [AW-1:0] acc_i_q, acc_i_d, acc_q_q, acc_q_d;
    logic signed [AW-1:0] diff_i, diff_q;

    function automatic logic signed [WIDTH-1:0] sat(input logic signed [AW-1:0] v);
        if (v > SAT_MAX) return SAT_MAX[WIDTH-1:0];
        if (v < SAT_MIN) return SAT_MIN[WIDTH-1:0];
        return v[WIDTH-1:0];
    endfunction

    assign diff_i = AW'(x_i) - (acc_i_q >>> DC_SHIFT);
    assign diff_q = AW'(x_q) - (acc_q_q >>> DC_SHIFT);

    always_comb begin
        real_d  = real_q;
        imag_d  = imag_q;
        acc_i_d = acc_i_q;
        acc_q_d = acc_q_q;
        if (pair_done) begin
            real_d  = sat(diff_i);
            imag_d  = sat(diff_q);
            acc_i_d = acc_i_q + diff_i;
            acc_q_d = acc_q_q + diff_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_i_q <= '0;
            acc_q_q <= '0;
        end else begin
            acc_i_q <= acc_i_d;
            acc_q_q <= acc_q_d;
        end
    end
`else
    always_comb begin
        real_d = real_q;
        imag_d = imag_q;
        if (pair_done) begin
            real_d = x_i;
            imag_d = x_q;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_I;
            ibyte_q  <= '0;
            cnt_q    <= '0;
            desync_q <= 1'b0;
            strobe_q <= 1'b0;
            real_q   <= '0;
            imag_q   <= '0;
        end else begin
            state_q  <= state_d;
            ibyte_q  <= ibyte_d;
            cnt_q    <= cnt_d;
            desync_q <= desync_d;
            strobe_q <= pair_done;
            real_q   <= real_d;
            imag_q   <= imag_d;
        end
    end

    assign real_o           = real_q;
    assign imag_o           = imag_q;
    assign merge_finished_o = strobe_q;
    assign desync_o         = desync_q;

endmodule

// File: tb/tb_iq_byte_merge.sv
// Directed bench for iq_byte_merge (WIDTH=16, TIMEOUT=255, DC removal off).
module tb_iq_byte_merge;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               byte_valid_i = 1'b0;
    logic [7:0]         byte_i = 8'h00;
    logic               sync_i = 1'b0;
    logic signed [15:0] real_o, imag_o;
    logic               merge_finished_o, desync_o;

    int tests = 0;
    int fails = 0;

    iq_byte_merge #(.WIDTH(16), .TIMEOUT(255), .DC_SHIFT(10)) dut (
        .clk              (clk),
        .rst              (rst),
        .byte_valid_i     (byte_valid_i),
        .byte_i           (byte_i),
        .sync_i           (sync_i),
        .real_o           (real_o),
        .imag_o           (imag_o),
        .merge_finished_o (merge_finished_o),
        .desync_o         (desync_o)
    );

    always #5 clk = ~clk;

    // Apply inputs for one clock, then settle just past the edge.
    task automatic step(input logic r, input logic v, input logic s, input logic [7:0] b);
        rst          = r;
        byte_valid_i = v;
        sync_i       = s;
        byte_i       = b;
        @(posedge clk);
        #1;
        rst          = 1'b0;
        byte_valid_i = 1'b0;
        sync_i       = 1'b0;
        byte_i       = 8'h00;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [15:0] re, input logic [15:0] im,
                           input logic stb, input logic ds);
        chk({tag, " real"},   real_o, re);
        chk({tag, " imag"},   imag_o, im);
        chk({tag, " strobe"}, {15'b0, merge_finished_o}, {15'b0, stb});
        chk({tag, " desync"}, {15'b0, desync_o}, {15'b0, ds});
    endtask

    initial begin
        step(1, 0, 0, 8'h00);
        step(1, 1, 1, 8'h5A);
        chk_out("reset", 16'h0000, 16'h0000, 1'b0, 1'b0);

        // 1: zero pair
        step(0, 1, 0, 8'h80);
        chk_out("t1 after I", 16'h0000, 16'h0000, 1'b0, 1'b0);
        step(0, 1, 0, 8'h80);
        chk_out("t1 pair", 16'h0000, 16'h0000, 1'b1, 1'b0);
        step(0, 0, 0, 8'h00);
        chk_out("t1 idle", 16'h0000, 16'h0000, 1'b0, 1'b0);

        // 2: full-scale extremes
        step(0, 1, 0, 8'hFF);
        step(0, 1, 0, 8'h00);
        chk_out("t2 pair", 16'h7F00, 16'h8000, 1'b1, 1'b0);

        // 3: back-to-back stream, outputs hold between strobes
        step(0, 1, 0, 8'h90);
        chk_out("t3 held", 16'h7F00, 16'h8000, 1'b0, 1'b0);
        step(0, 1, 0, 8'h70);
        chk_out("t3 pair1", 16'h1000, 16'hF000, 1'b1, 1'b0);
        step(0, 1, 0, 8'hA0);
        chk_out("t3 gap", 16'h1000, 16'hF000, 1'b0, 1'b0);
        step(0, 1, 0, 8'h60);
        chk_out("t3 pair2", 16'h2000, 16'hE000, 1'b1, 1'b0);

        // sync alone in S_I has no effect
        step(0, 0, 1, 8'h00);
        chk_out("sync idle S_I", 16'h2000, 16'hE000, 1'b0, 1'b0);

        // 4: sync-tagged byte mid-pair becomes the new I
        step(0, 1, 0, 8'h90);
        step(0, 1, 1, 8'h10);
        chk_out("t4 resync", 16'h2000, 16'hE000, 1'b0, 1'b1);
        step(0, 1, 0, 8'hA0);
        chk_out("t4 pair", 16'h9000, 16'h2000, 1'b1, 1'b1);
        step(0, 0, 0, 8'h00);
        chk_out("t4 sticky", 16'h9000, 16'h2000, 1'b0, 1'b1);

        // 5: timeout after 255 idle cycles
        step(1, 0, 0, 8'h00);
        chk_out("t5 reset", 16'h0000, 16'h0000, 1'b0, 1'b0);
        step(0, 1, 0, 8'h33);
        for (int i = 0; i < 254; i++) step(0, 0, 0, 8'h00);
        chk_out("t5 idle 254", 16'h0000, 16'h0000, 1'b0, 1'b0);
        step(0, 0, 0, 8'h00);
        chk_out("t5 idle 255", 16'h0000, 16'h0000, 1'b0, 1'b1);
        step(0, 1, 0, 8'h81);
        step(0, 1, 0, 8'h82);
        chk_out("t5 pair", 16'h0100, 16'h0200, 1'b1, 1'b1);

        // byte on the last permitted idle cycle is still taken as Q
        step(1, 0, 0, 8'h00);
        step(0, 1, 0, 8'hC0);
        for (int i = 0; i < 254; i++) step(0, 0, 0, 8'h00);
        step(0, 1, 0, 8'h40);
        chk_out("byte wins", 16'h4000, 16'hC000, 1'b1, 1'b0);

        // sync alone in S_Q drops the held I and realigns
        step(0, 1, 0, 8'h40);
        step(0, 0, 1, 8'h00);
        chk_out("sync drop", 16'h4000, 16'hC000, 1'b0, 1'b1);
        step(0, 1, 0, 8'h81);
        step(0, 1, 0, 8'h82);
        chk_out("sync realign", 16'h0100, 16'h0200, 1'b1, 1'b1);

        // 6: reset mid-pair discards the held I
        step(0, 1, 0, 8'hFF);
        step(0, 1, 0, 8'hFF);
        chk_out("t6 pre", 16'h7F00, 16'h7F00, 1'b1, 1'b1);
        step(0, 1, 0, 8'h11);
        step(1, 1, 0, 8'h22);
        chk_out("t6 reset", 16'h0000, 16'h0000, 1'b0, 1'b0);
        step(0, 1, 0, 8'h88);
        chk_out("t6 after I", 16'h0000, 16'h0000, 1'b0, 1'b0);
        step(0, 1, 0, 8'h78);
        chk_out("t6 pair", 16'h0800, 16'hF800, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
